// File: rtl/hit_ts_pkg.sv
// Shared widths, wrap limits and timestamp layout for the hit timestamper.
// The packed struct describes the default-width timestamp word {min, sec, ms, fine}.
package hit_ts_pkg;

    localparam int SEC_W      = 6;
    localparam int MS_W       = 10;
    localparam int MIN_W_DEF  = 16;
    localparam int FINE_W_DEF = 13;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;

    typedef struct packed {
        logic [MIN_W_DEF-1:0]  min;
        logic [SEC_W-1:0]      sec;
        logic [MS_W-1:0]       ms;
        logic [FINE_W_DEF-1:0] fine;
    } hit_ts_t;

endpackage

// File: rtl/hit_ts_fifo.sv
// First-word-fall-through FIFO with a registered head word and valid flag.
// A push while full is accepted only when the head is popped in the same cycle.
module hit_ts_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_n_s;
    logic [PTR_W-1:0] rd_ptr_n_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_left_s;
    logic [CNT_W-1:0] count_n_s;
    logic             pop_ok_s;
    logic             push_ok_s;
    logic [W-1:0]     dout_n_s;

    assign full = (count_r == CNT_FULL);

    // Next pointers, occupancy and head word
    always_comb begin
        pop_ok_s     = pop & valid;
        push_ok_s    = push & (~full | pop_ok_s);
        count_left_s = count_r - CNT_W'(pop_ok_s);
        count_n_s    = count_left_s + CNT_W'(push_ok_s);

        if (pop_ok_s) begin
            rd_ptr_n_s = (rd_ptr_r == PTR_LAST) ? PTR_ZERO : rd_ptr_r + PTR_W'(1'b1);
        end else begin
            rd_ptr_n_s = rd_ptr_r;
        end

        if (push_ok_s) begin
            wr_ptr_n_s = (wr_ptr_r == PTR_LAST) ? PTR_ZERO : wr_ptr_r + PTR_W'(1'b1);
        end else begin
            wr_ptr_n_s = wr_ptr_r;
        end

        // An empty FIFO keeps presenting the last word it delivered
        if (count_n_s == CNT_ZERO) begin
            dout_n_s = dout;
        end else if (count_left_s == CNT_ZERO) begin
            dout_n_s = din;
        end else begin
            dout_n_s = mem_r[rd_ptr_n_s];
        end
    end

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            dout     <= {W{1'b0}};
            valid    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_n_s;
            rd_ptr_r <= rd_ptr_n_s;
            count_r  <= count_n_s;
            dout     <= dout_n_s;
            valid    <= (count_n_s != CNT_ZERO);
        end
    end

endmodule

// File: rtl/hit_timestamper.sv
// Rebuilds time-of-day from the divider toggles and timestamps synchronised hit edges into a FIFO.
// Optional per-second accepted-hit rate output: define HIT_TIMESTAMPER_RATE_EN.
module hit_timestamper
    import hit_ts_pkg::*;
#(
    parameter int MIN_W      = 16,
    parameter int FINE_W     = 13,
    parameter int FIFO_DEPTH = 4,
    parameter int HOLDOFF    = 8
) (
    input  logic                                 CLK,
    input  logic                                 RST_N,
    input  logic                                 ms_tgl,
    input  logic                                 sec_tgl,
    input  logic                                 min_tgl,
    input  logic                                 hit,
    output logic [MIN_W+SEC_W+MS_W+FINE_W-1:0]   ts_data,
    output logic                                 ts_valid,
    input  logic                                 ts_ready,
    output logic [7:0]                           drop_cnt,
    output logic                                 overflow
`ifdef HIT_TIMESTAMPER_RATE_EN
    ,
    output logic [15:0]                          rate_cnt,
    output logic                                 rate_valid
`endif
);

    localparam int TS_W = MIN_W + SEC_W + MS_W + FINE_W;
    localparam int HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [FINE_W-1:0] FINE_MAX = {FINE_W{1'b1}};
    localparam logic [HO_W-1:0]   HO_LOAD  = HO_W'(HOLDOFF);
    localparam logic [HO_W-1:0]   HO_ZERO  = {HO_W{1'b0}};

    logic              init_r;
    logic              ms_prev_r;
    logic              sec_prev_r;
    logic              min_prev_r;
    logic              ms_edge_s;
    logic              sec_edge_s;
    logic              min_edge_s;

    logic [MIN_W-1:0]  min_r;
    logic [SEC_W-1:0]  sec_r;
    logic [MS_W-1:0]   ms_r;
    logic [FINE_W-1:0] fine_r;
    logic [MIN_W-1:0]  min_n_s;
    logic [SEC_W-1:0]  sec_n_s;
    logic [MS_W-1:0]   ms_n_s;
    logic [FINE_W-1:0] fine_n_s;

    logic              hit_meta_r;
    logic              hit_sync_r;
    logic              hit_last_r;
    logic [HO_W-1:0]   holdoff_r;
    logic              detect_s;
    logic              pop_s;
    logic              full_s;
    logic              push_s;
    logic              drop_s;
    logic [TS_W-1:0]   capture_s;

    assign ms_edge_s  = init_r & (ms_tgl ^ ms_prev_r);
    assign sec_edge_s = init_r & (sec_tgl ^ sec_prev_r);
    assign min_edge_s = init_r & (min_tgl ^ min_prev_r);

    // Previous toggle copies; the first cycle after reset only loads them
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            init_r     <= 1'b0;
            ms_prev_r  <= 1'b0;
            sec_prev_r <= 1'b0;
            min_prev_r <= 1'b0;
        end else begin
            init_r     <= 1'b1;
            ms_prev_r  <= ms_tgl;
            sec_prev_r <= sec_tgl;
            min_prev_r <= min_tgl;
        end
    end

    // Time-of-day next state, min edge dominating sec dominating ms
    always_comb begin
        min_n_s  = min_r;
        sec_n_s  = sec_r;
        ms_n_s   = ms_r;
        fine_n_s = fine_r;
        if (min_edge_s) begin
            min_n_s  = min_r + MIN_W'(1'b1);
            sec_n_s  = {SEC_W{1'b0}};
            ms_n_s   = {MS_W{1'b0}};
            fine_n_s = {FINE_W{1'b0}};
        end else if (sec_edge_s) begin
            sec_n_s  = (sec_r == SEC_MAX) ? {SEC_W{1'b0}} : sec_r + 6'd1;
            ms_n_s   = {MS_W{1'b0}};
            fine_n_s = {FINE_W{1'b0}};
        end else if (ms_edge_s) begin
            ms_n_s   = (ms_r == MS_MAX) ? ms_r : ms_r + 10'd1;
            fine_n_s = {FINE_W{1'b0}};
        end else begin
            fine_n_s = (fine_r == FINE_MAX) ? fine_r : fine_r + FINE_W'(1'b1);
        end
    end

    // Time-of-day registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            min_r  <= {MIN_W{1'b0}};
            sec_r  <= {SEC_W{1'b0}};
            ms_r   <= {MS_W{1'b0}};
            fine_r <= {FINE_W{1'b0}};
        end else begin
            min_r  <= min_n_s;
            sec_r  <= sec_n_s;
            ms_r   <= ms_n_s;
            fine_r <= fine_n_s;
        end
    end

    // Two-flop synchroniser plus a delayed copy for rising-edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hit_meta_r <= 1'b0;
            hit_sync_r <= 1'b0;
            hit_last_r <= 1'b0;
        end else begin
            hit_meta_r <= hit;
            hit_sync_r <= hit_meta_r;
            hit_last_r <= hit_sync_r;
        end
    end

    // Capture uses the current registers, i.e. before this cycle's tick update
    assign detect_s  = hit_sync_r & ~hit_last_r & (holdoff_r == HO_ZERO);
    assign pop_s     = ts_valid & ts_ready;
    assign push_s    = detect_s & (~full_s | pop_s);
    assign drop_s    = detect_s & full_s & ~pop_s;
    assign capture_s = {min_r, sec_r, ms_r, fine_r};

    // Holdoff window after every detected edge, kept or dropped
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            holdoff_r <= HO_ZERO;
        end else if (detect_s) begin
            holdoff_r <= HO_LOAD;
        end else if (holdoff_r != HO_ZERO) begin
            holdoff_r <= holdoff_r - HO_W'(1'b1);
        end else begin
            holdoff_r <= holdoff_r;
        end
    end

    // Lost-hit statistics, cleared only by reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop_cnt <= 8'd0;
            overflow <= 1'b0;
        end else if (drop_s) begin
            drop_cnt <= (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
            overflow <= 1'b1;
        end else begin
            drop_cnt <= drop_cnt;
            overflow <= overflow;
        end
    end

    hit_ts_fifo #(
        .W     (TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push_s),
        .din   (capture_s),
        .pop   (pop_s),
        .dout  (ts_data),
        .valid (ts_valid),
        .full  (full_s)
    );

`ifdef HIT_TIMESTAMPER_RATE_EN
    logic [15:0] rate_run_r;

    // Per-second accepted-hit count; a hit on the boundary belongs to the new second
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rate_run_r <= 16'd0;
            rate_cnt   <= 16'd0;
            rate_valid <= 1'b0;
        end else if (sec_edge_s | min_edge_s) begin
            rate_cnt   <= rate_run_r;
            rate_valid <= 1'b1;
            rate_run_r <= push_s ? 16'd1 : 16'd0;
        end else begin
            rate_cnt   <= rate_cnt;
            rate_valid <= 1'b0;
            if (push_s && (rate_run_r != 16'hFFFF)) begin
                rate_run_r <= rate_run_r + 16'd1;
            end else begin
                rate_run_r <= rate_run_r;
            end
        end
    end
`endif

endmodule
